wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback stage plus architectural register file; consumer side of the MEM/WB pipeline register.
//  - Selects load data or ALU result and writes it to the register file.
//  - Serves the two ID-stage read ports, with same-cycle write-through bypass.
//  - Exports the writeback value for EX-stage forwarding.
//  - Keeps a 64-bit retired-instruction counter.
// PARAMETERS
//  XLEN    64  data width of registers, write data and read data
//  NREG    32  number of architectural registers; x0 is hardwired to zero
//  AW      5   register address width, equal to log2(NREG)
//  BYPASS  1   1 = read ports return the same-cycle write data; 0 = read the array only
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     asynchronous, active-high reset
//  valid_d4       in   1     MEM/WB slot holds a real (non-bubble) instruction
//  mem_to_reg_d4  in   1     1 = write read_data_d4; 0 = write alu_result_d4
//  reg_write_d4   in   1     instruction writes rd
//  read_data_d4   in   XLEN  load data from MEM/WB
//  alu_result_d4  in   XLEN  ALU result from MEM/WB
//  rd_d4          in   AW    destination register from MEM/WB
//  rs1_addr       in   AW    ID read port 1 address
//  rs2_addr       in   AW    ID read port 2 address
//  rs1_data       out  XLEN  read port 1 data (combinational)
//  rs2_data       out  XLEN  read port 2 data (combinational)
//  wb_data        out  XLEN  selected writeback value (combinational)
//  wb_rd          out  AW    equals rd_d4
//  wb_en          out  1     qualified write enable, for the forwarding unit
//  instret        out  64    count of retired instructions (registered)
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - All NREG array entries clear to 0.
//    - instret clears to 0.
//    - Outputs are combinational from inputs and the cleared array, so rsX_data reads 0.
//  - wb_data = mem_to_reg_d4 ? read_data_d4 : alu_result_d4.
//  - wb_en = valid_d4 & reg_write_d4 & (rd_d4 != 0).
//  - Write: at a rising clk edge with wb_en=1, array[rd_d4] <= wb_data. Written data is readable from the array one cycle later.
//  - x0:
//    - Never written; any write to rd=0 is dropped.
//    - rsX_addr == 0 always reads 0, including under bypass.
//  - Read, per port (rs1 and rs2 handled identically and independently):
//    - rsX_data = 0 if rsX_addr == 0.
//    - Otherwise, with BYPASS=1 and wb_en=1 and rd_d4 == rsX_addr: rsX_data = wb_data.
//    - Otherwise rsX_data = array[rsX_addr].
//    - Both ports may hit the same address or the bypass simultaneously; both return identical data.
//  - instret: increments by 1 on each clk edge where valid_d4=1, independent of reg_write_d4. Wraps from 2^64-1 to 0 with no flag.
//  - Bubbles (valid_d4=0): no write, no count. Stale reg_write_d4 is ignored.
//  - Reset mid-operation: rst=1 in the same cycle as a write means the reset wins and the array stays 0. The first write is accepted at the first edge after rst falls.
//  - No X propagation: the array reset guarantees defined reads from cycle 0.
// TESTING
//  - Reset: assert rst mid-run after writes -> rs1_data, rs2_data read 0 for all addresses; instret=0.
//  - Basic write/read: valid=1, reg_write=1, mem_to_reg=0, alu_result=64'hDEAD_BEEF_0000_0001, rd=5 -> next cycle rs1_addr=5 reads 64'hDEAD_BEEF_0000_0001.
//  - Load select: mem_to_reg=1, read_data=64'h1234, alu_result=64'hFFFF, rd=7 -> array[7]=64'h1234; wb_data=64'h1234 in the same cycle.
//  - Bypass: write rd=9 with 64'hA5 while rs1_addr=rs2_addr=9 -> both ports return 64'hA5 in the same cycle. With BYPASS=0 both return the old value.
//  - x0 and bubbles:
//    - Write rd=0 with 64'hFF -> rs1_addr=0 reads 0; wb_en=0.
//    - valid=0, reg_write=1, rd=3 -> array[3] unchanged; instret unchanged.
//  - Counter: 10 valid cycles -> instret=10. Force instret to 2^64-1, then one valid cycle -> instret=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// writes it into the array, serves two bypassed read ports and counts retired instructions.
module wb_regfile #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_d4,
  input  logic            mem_to_reg_d4,
  input  logic            reg_write_d4,
  input  logic [XLEN-1:0] read_data_d4,
  input  logic [XLEN-1:0] alu_result_d4,
  input  logic [AW-1:0]   rd_d4,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   wb_rd,
  output logic            wb_en,
  output logic [63:0]     instret
);

  logic [XLEN-1:0] regs [NREG];

  assign wb_data = mem_to_reg_d4 ? read_data_d4 : alu_result_d4;
  assign wb_rd   = rd_d4;
  // x0 is excluded here, so the array entry 0 is never written and stays zero
  assign wb_en   = valid_d4 & reg_write_d4 & (rd_d4 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[rd_d4] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (valid_d4) begin
      instret <= instret + 64'd1;
    end
  end

  // Write-through bypass lets ID see a value being retired in the same cycle
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if ((BYPASS != 0) && wb_en && (rd_d4 == rs1_addr)) begin
      rs1_data = wb_data;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if ((BYPASS != 0) && wb_en && (rd_d4 == rs2_addr)) begin
      rs2_data = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a vector table for the per-cycle behaviour plus
// hand-written sequences for reset, reset-versus-write and counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d4, mem_to_reg_d4, reg_write_d4;
  logic [63:0] read_data_d4, alu_result_d4;
  logic [4:0]  rd_d4, rs1_addr, rs2_addr;

  logic [63:0] rs1_data, rs2_data, wb_data, instret;
  logic [4:0]  wb_rd;
  logic        wb_en;

  logic [63:0] nb_rs1_data, nb_rs2_data, nb_wb_data, nb_instret;
  logic [4:0]  nb_wb_rd;
  logic        nb_wb_en;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .valid_d4(valid_d4), .mem_to_reg_d4(mem_to_reg_d4),
    .reg_write_d4(reg_write_d4), .read_data_d4(read_data_d4), .alu_result_d4(alu_result_d4),
    .rd_d4(rd_d4), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en), .instret(instret)
  );

  wb_regfile #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .valid_d4(valid_d4), .mem_to_reg_d4(mem_to_reg_d4),
    .reg_write_d4(reg_write_d4), .read_data_d4(read_data_d4), .alu_result_d4(alu_result_d4),
    .rd_d4(rd_d4), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb_rs1_data),
    .rs2_data(nb_rs2_data), .wb_data(nb_wb_data), .wb_rd(nb_wb_rd), .wb_en(nb_wb_en),
    .instret(nb_instret)
  );

  typedef struct {
    logic        valid;
    logic        m2r;
    logic        rw;
    logic [63:0] rdata;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] e_wb;
    logic        e_en;
    logic [63:0] e_rs1;
    logic [63:0] e_rs2;
    logic [63:0] e_nb1;
    logic [63:0] e_nb2;
    logic [63:0] e_instret;
  } vec_t;

  vec_t vecs [9];

  task automatic applyStimulus(input logic v, input logic m2r, input logic rw,
                               input logic [63:0] rdata, input logic [63:0] alu,
                               input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
    valid_d4      = v;
    mem_to_reg_d4 = m2r;
    reg_write_d4  = rw;
    read_data_d4  = rdata;
    alu_result_d4 = alu;
    rd_d4         = rd;
    rs1_addr      = a1;
    rs2_addr      = a2;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    // Table sequence starts from a freshly reset array with instret = 0
    vecs[0] = '{1'b1, 1'b0, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd1, 5'd0,
                64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0, 64'h0, 64'h0, 64'h0, 64'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 64'h1234, 64'hFFFF, 5'd7, 5'd5, 5'd7,
                64'h1234, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h1234,
                64'hDEAD_BEEF_0000_0001, 64'h0, 64'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 64'h0, 64'hA5, 5'd9, 5'd9, 5'd9,
                64'hA5, 1'b1, 64'hA5, 64'hA5, 64'h0, 64'h0, 64'd2};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 64'h0, 64'hFF, 5'd0, 5'd0, 5'd7,
                64'hFF, 1'b0, 64'h0, 64'h1234, 64'h0, 64'h1234, 64'd3};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h77, 5'd3, 5'd3, 5'd9,
                64'h77, 1'b0, 64'h0, 64'hA5, 64'h0, 64'hA5, 64'd4};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd3, 5'd5,
                64'h0, 1'b0, 64'h0, 64'hDEAD_BEEF_0000_0001,
                64'h0, 64'hDEAD_BEEF_0000_0001, 64'd4};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 64'h0, 64'h55, 5'd5, 5'd5, 5'd5,
                64'h55, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001,
                64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 64'd4};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 64'h0, 64'hBB, 5'd5, 5'd5, 5'd9,
                64'hBB, 1'b1, 64'hBB, 64'hA5, 64'hDEAD_BEEF_0000_0001, 64'hA5, 64'd5};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd7,
                64'h0, 1'b0, 64'hBB, 64'h1234, 64'hBB, 64'h1234, 64'd6};

    rst = 1'b1;
    bubble();
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    #2;
    checkOutput("reset_instret", instret, 64'd0);
    checkOutput("reset_rs1", rs1_data, 64'd0);
    checkOutput("reset_rs2", rs2_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].valid, vecs[i].m2r, vecs[i].rw, vecs[i].rdata, vecs[i].alu,
                    vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      #2;
      checkOutput($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wb);
      checkOutput($sformatf("v%0d_wb_en", i), {63'd0, wb_en}, {63'd0, vecs[i].e_en});
      checkOutput($sformatf("v%0d_wb_rd", i), {59'd0, wb_rd}, {59'd0, vecs[i].rd});
      checkOutput($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e_rs1);
      checkOutput($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e_rs2);
      checkOutput($sformatf("v%0d_nb_rs1", i), nb_rs1_data, vecs[i].e_nb1);
      checkOutput($sformatf("v%0d_nb_rs2", i), nb_rs2_data, vecs[i].e_nb2);
      checkOutput($sformatf("v%0d_nb_wb_en", i), {63'd0, nb_wb_en}, {63'd0, vecs[i].e_en});
      checkOutput($sformatf("v%0d_nb_wb_data", i), nb_wb_data, vecs[i].e_wb);
      checkOutput($sformatf("v%0d_nb_wb_rd", i), {59'd0, nb_wb_rd}, {59'd0, vecs[i].rd});
      checkOutput($sformatf("v%0d_instret", i), instret, vecs[i].e_instret);
    end
    @(negedge clk);
    bubble();
    #2;
    checkOutput("table_instret", instret, 64'd6);
    checkOutput("table_nb_instret", nb_instret, 64'd6);

    // Asynchronous reset mid-run clears every entry and the counter
    rst = 1'b1;
    #1;
    checkOutput("midrst_instret", instret, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = a[4:0];
      rs2_addr = 5'(31 - a);
      #1;
      checkOutput($sformatf("midrst_rs1_x%0d", a), rs1_data, 64'd0);
      checkOutput($sformatf("midrst_rs2_x%0d", 31 - a), rs2_data, 64'd0);
    end

    // A write presented while reset is held is lost
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0, 64'h44, 5'd4, 5'd4, 5'd4);
    @(negedge clk);
    rst = 1'b0;
    bubble();
    rs1_addr = 5'd4;
    #2;
    checkOutput("rstwin_rs1", rs1_data, 64'd0);
    checkOutput("rstwin_instret", instret, 64'd0);

    // First edge after reset release accepts the write
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0, 64'h44, 5'd4, 5'd4, 5'd4);
    @(negedge clk);
    bubble();
    rs1_addr = 5'd4;
    rs2_addr = 5'd4;
    #2;
    checkOutput("postrst_rs1", rs1_data, 64'h44);
    checkOutput("postrst_rs2", rs2_data, 64'h44);
    checkOutput("postrst_instret", instret, 64'd1);

    // Ten valid non-writing cycles after a fresh reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 64'h99, 5'd6, 5'd6, 5'd0);
    end
    @(negedge clk);
    bubble();
    rs1_addr = 5'd6;
    #2;
    checkOutput("count10_instret", instret, 64'd10);
    checkOutput("count10_rs1", rs1_data, 64'd0);

    // Counter wrap from all-ones
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    checkOutput("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    bubble();
    #2;
    checkOutput("wrap_instret", instret, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
